// File: rtl/bus_term_fifo.sv
// Show-ahead bus-terminating FIFO: agent writes, bus sees the head entry and pops it.
// Writes are dropped and counted while full, and a pop while empty sets a sticky flag.
module bus_term_fifo #(
    parameter int unsigned bits  = 16,
    parameter int unsigned depth = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [bits-1:0]              wr_data,
    output logic                         full,
    output logic                         pndng,
    output logic [bits-1:0]              D_pop,
    input  logic                         pop,
    output logic [$clog2(depth+1)-1:0]   count,
    output logic [7:0]                   drop_cnt,
    output logic                         underflow
);

    localparam int unsigned PW = $clog2(depth);
    localparam int unsigned CW = $clog2(depth + 1);

    logic [bits-1:0] mem_q [depth];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      drop_q, drop_d;
    logic            underflow_q, underflow_d;

    logic            pop_ok;
    logic            wr_ok;

    assign full      = (count_q == CW'(depth));
    assign pndng     = (count_q != '0);
    assign D_pop     = pndng ? mem_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign drop_cnt  = drop_q;
    assign underflow = underflow_q;

    // A pop frees a slot in the same cycle, so a write is accepted even when full.
    assign pop_ok = pop && pndng;
    assign wr_ok  = wr_en && (!full || pop_ok);

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        drop_d      = drop_q;
        underflow_d = underflow_q;

        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        case ({wr_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (wr_en && !wr_ok && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
        if (pop && !pndng) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            drop_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            drop_q      <= drop_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; gating on reset keeps inputs ignored while it is held.
    always_ff @(posedge clock) begin
        if (wr_ok && !reset) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_bus_term_fifo.sv
// Bench for bus_term_fifo: directed scenarios plus random traffic against a queue model.
module tb_bus_term_fifo;

    localparam int unsigned BITS  = 16;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic            clock;
    logic            reset;
    logic            wr_en;
    logic [BITS-1:0] wr_data;
    logic            full;
    logic            pndng;
    logic [BITS-1:0] D_pop;
    logic            pop;
    logic [CW-1:0]   count;
    logic [7:0]      drop_cnt;
    logic            underflow;

    bus_term_fifo #(.bits(BITS), .depth(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .pndng     (pndng),
        .D_pop     (D_pop),
        .pop       (pop),
        .count     (count),
        .drop_cnt  (drop_cnt),
        .underflow (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    logic [BITS-1:0] model_q[$];
    int              model_drops = 0;
    bit              model_uflow = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        logic [31:0] exp_head;
        int          sz;
        sz       = model_q.size();
        exp_head = (sz > 0) ? 32'(model_q[0]) : 32'd0;
        chk({tag, ".count"},     32'(count),     32'(sz));
        chk({tag, ".full"},      32'(full),      32'(sz == DEPTH));
        chk({tag, ".pndng"},     32'(pndng),     32'(sz != 0));
        chk({tag, ".D_pop"},     32'(D_pop),     exp_head);
        chk({tag, ".drop_cnt"},  32'(drop_cnt),  32'(model_drops));
        chk({tag, ".underflow"}, 32'(underflow), 32'(model_uflow));
    endtask

    // One clock of traffic; the model applies the FIFO rules to the pre-edge state.
    task automatic cycle(input bit we, input logic [BITS-1:0] wd, input bit p, input string tag);
        bit pop_acc;
        bit wr_acc;
        int sz;
        @(negedge clock);
        wr_en   = we;
        wr_data = wd;
        pop     = p;
        @(posedge clock);
        sz      = model_q.size();
        pop_acc = p && (sz > 0);
        wr_acc  = we && ((sz < DEPTH) || pop_acc);
        if (p && sz == 0) model_uflow = 1'b1;
        if (we && !wr_acc && model_drops < 255) model_drops++;
        if (pop_acc) void'(model_q.pop_front());
        if (wr_acc) model_q.push_back(wd);
        #1;
        chk_model(tag);
    endtask

    task automatic model_clear();
        model_q.delete();
        model_drops = 0;
        model_uflow = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [BITS-1:0] exp_word;
        int              next_pop;
        bit              p;

        // Reset held over an edge with active inputs: nothing may be captured.
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 16'h1234;
        pop     = 1'b1;
        @(posedge clock);
        #1;
        model_clear();
        chk_model("reset");
        @(negedge clock);
        wr_en = 1'b0;
        pop   = 1'b0;
        reset = 1'b0;

        // Fill then drain.
        for (int i = 1; i <= 8; i++) cycle(1'b1, BITS'(i), 1'b0, "fill");
        chk("fill.full_const", 32'(full), 32'd1);
        chk("fill.count_const", 32'(count), 32'd8);
        for (int i = 1; i <= 8; i++) begin
            chk("drain.order", 32'(D_pop), 32'(i));
            cycle(1'b0, '0, 1'b1, "drain");
        end
        chk("drain.pndng_const", 32'(pndng), 32'd0);

        // Overflow drops.
        for (int i = 1; i <= 8; i++) cycle(1'b1, BITS'(i), 1'b0, "refill");
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'hDEAD, 1'b0, "ovf");
        chk("ovf.drop3", 32'(drop_cnt), 32'd3);
        chk("ovf.head", 32'(D_pop), 32'h0001);

        // Push and pop together while full.
        cycle(1'b1, 16'hBEEF, 1'b1, "fullpp");
        chk("fullpp.count", 32'(count), 32'd8);
        chk("fullpp.drop", 32'(drop_cnt), 32'd3);
        for (int i = 1; i <= 8; i++) begin
            exp_word = (i == 8) ? 16'hBEEF : BITS'(i + 1);
            chk("fullpp.order", 32'(D_pop), 32'(exp_word));
            cycle(1'b0, '0, 1'b1, "fullpp_drain");
        end

        // Saturating drop counter.
        for (int i = 1; i <= 8; i++) cycle(1'b1, BITS'(i), 1'b0, "refill2");
        for (int i = 0; i < 300; i++) cycle(1'b1, 16'hDEAD, 1'b0, "sat");
        chk("sat.drop255", 32'(drop_cnt), 32'd255);
        for (int i = 0; i < 8; i++) cycle(1'b0, '0, 1'b1, "sat_drain");

        // Underflow, then sticky through later traffic; push+pop while empty.
        cycle(1'b0, '0, 1'b1, "uflow");
        chk("uflow.flag", 32'(underflow), 32'd1);
        chk("uflow.count", 32'(count), 32'd0);
        cycle(1'b1, 16'h0055, 1'b1, "uflow_wp_empty");
        cycle(1'b0, '0, 1'b1, "uflow_pop");
        chk("uflow.sticky", 32'(underflow), 32'd1);

        // Wrap-around with interleaved writes and pops at occupancy 1..3.
        next_pop = 0;
        for (int i = 0; i < 20; i++) begin
            p = (model_q.size() >= 1) && ((model_q.size() == 3) || ($urandom_range(1, 0) == 1));
            if (p) begin
                chk("wrap.seq", 32'(D_pop), 32'(16'h0100 + 16'(next_pop)));
                next_pop++;
            end
            cycle(1'b1, 16'h0100 + 16'(i), p, "wrap");
        end
        while (model_q.size() > 0) begin
            chk("wrap.seq", 32'(D_pop), 32'(16'h0100 + 16'(next_pop)));
            next_pop++;
            cycle(1'b0, '0, 1'b1, "wrap_drain");
        end
        chk("wrap.total", 32'(next_pop), 32'd20);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(1, 0)), 16'($urandom), 1'($urandom_range(1, 0)), "rand");
        end

        // Mid-operation reset pulse between edges.
        while (model_q.size() > 0) cycle(1'b0, '0, 1'b1, "pre_rst_drain");
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'h0A00 + 16'(i), 1'b0, "mid");
        wr_en = 1'b0;
        pop   = 1'b0;
        #1 reset = 1'b1;
        #1;
        model_clear();
        chk_model("midrst");
        #2 reset = 1'b0;
        cycle(1'b1, 16'h00AA, 1'b0, "post_rst");
        chk("post_rst.head", 32'(D_pop), 32'h00AA);
        cycle(1'b0, '0, 1'b1, "post_rst_pop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_term_fifo.md
BUS_TERM_FIFO -- requirements
Module: bus_term_fifo

Interface
REQ-001 The block SHALL have parameter bits, default 16, giving the data word width in bits.
REQ-002 The block SHALL have parameter depth, default 8, giving the number of entries; it is a power of two and at least 2.
REQ-003 The block SHALL have one clock, port clock; reset is asynchronous and active-high, port reset.
REQ-004 The block SHALL have the port: clock  input  1  rising-edge clock for all state.
REQ-005 The block SHALL have the port: reset  input  1  asynchronous active-high reset.
REQ-006 The block SHALL have the port: wr_en  input  1  agent-side write request.
REQ-007 The block SHALL have the port: wr_data  input  bits  agent-side write word.
REQ-008 The block SHALL have the port: full  output  1  occupancy equals depth.
REQ-009 The block SHALL have the port: pndng  output  1  at least one entry held, presented to the bus.
REQ-010 The block SHALL have the port: D_pop  output  bits  head entry, presented to the bus (show-ahead).
REQ-011 The block SHALL have the port: pop  input  1  bus consumes the head entry.
REQ-012 The block SHALL have the port: count  output  $clog2(depth+1)  current occupancy.
REQ-013 The block SHALL have the port: drop_cnt  output  8  number of writes dropped while full; saturates.
REQ-014 The block SHALL have the port: underflow  output  1  sticky flag, set when pop arrives while empty.

Function
REQ-015 Storage SHALL be a circular buffer with read and write pointers of $clog2(depth) bits that wrap from depth-1 to 0.
REQ-016 count SHALL be a registered value; full = (count==depth) and pndng = (count!=0).
REQ-017 D_pop SHALL combinationally equal mem[rd_ptr] while pndng=1, and SHALL be 0 while pndng=0.
REQ-018 A write accepted at edge N SHALL be visible at edge N+1: pndng=1, and D_pop equals that word if the FIFO was empty.
REQ-019 A write SHALL be accepted when wr_en=1 and (full=0, or pop=1 with pndng=1).
REQ-020 An accepted write SHALL store wr_data at wr_ptr and advance wr_ptr by 1.
REQ-021 A pop SHALL be accepted when pop=1 and pndng=1; rd_ptr then advances by 1.
REQ-022 Simultaneous accepted write and pop SHALL leave count unchanged, including at count=depth and at count=1.
REQ-023 wr_en=1 with full=1 and no accepted pop SHALL drop the word: storage and pointers unchanged, drop_cnt+1, drop_cnt holding at 255.
REQ-024 pop=1 with pndng=0 SHALL change no pointer or count and SHALL set underflow=1 on the next edge; underflow stays set until reset.
REQ-025 wr_en=1 with pop=1 while empty SHALL accept the write, ignore the pop, and set underflow.
REQ-026 Order SHALL be strictly first-in first-out; no entry is duplicated or lost except drops counted by REQ-023.

Reset
REQ-027 While reset=1, asynchronously, the block SHALL hold rd_ptr=0, wr_ptr=0, count=0, drop_cnt=0, underflow=0, making full=0, pndng=0 and D_pop=0.
REQ-028 Storage contents SHALL NOT require reset.
REQ-029 Reset asserted mid-transfer SHALL discard all entries; the first write after deassertion SHALL be the first word popped.
REQ-030 Inputs SHALL be ignored on the first rising edge at which reset is still 1.

Verification
REQ-031 The bench SHALL cover fill-then-drain: after reset, write 0x0001..0x0008 (depth=8) -> full=1 and count=8; then pop 8 times -> D_pop reads 0x0001..0x0008 in order, and pndng=0 after the 8th pop.
REQ-032 The bench SHALL cover overflow: with the FIFO full, write 0xDEAD three cycles with pop=0 -> drop_cnt=3, count=8, D_pop still 0x0001; 300 such writes -> drop_cnt=255.
REQ-033 The bench SHALL cover full push+pop: with count=8, wr_en=1 (0xBEEF) and pop=1 in the same cycle -> count stays 8, drop_cnt unchanged, and 0xBEEF emerges as the 8th word.
REQ-034 The bench SHALL cover underflow: when empty, pop=1 for one cycle -> underflow=1, count=0; underflow stays 1 through a later write and pop.
REQ-035 The bench SHALL cover wrap-around: 20 interleaved write/pop pairs at count=1..3 with words 0x0100+i -> popped sequence matches exactly with no gap.
REQ-036 The bench SHALL cover mid-op reset: write 5 words, pulse reset for a half cycle between edges -> count=0 and pndng=0 immediately; then write 0x00AA -> next edge D_pop=0x00AA.
